// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Per-bit switch debouncer. Each raw switch bit is brought into the clk
// domain through a two-flop synchronizer. A per-bit counter then measures
// how many consecutive cycles the synchronized level has disagreed with
// the debounced level. A bit is accepted only after STABLE_CYCLES such
// cycles in a row; any agreeing cycle restarts the measurement.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   rst        : asynchronous active-low reset
//   sw_in      : raw asynchronous switch levels [WIDTH]
//   sw_stable  : debounced switch vector [WIDTH]
//   chg_pulse  : one-cycle pulse on every edge where sw_stable changes
//   chg_mask   : bits of sw_stable that changed on that edge, else zero
//   chg_count  : 8-bit wrapping count of chg_pulse events
//   any_on     : OR-reduction of sw_stable, aligned with sw_stable
//
// Parameters
//   WIDTH          : number of switch bits
//   STABLE_CYCLES  : consecutive disagreeing cycles before accept (2..65535)
//   CNT_W          : counter width; must satisfy 2**CNT_W > STABLE_CYCLES
// -----------------------------------------------------------------------------
module sw_debounce #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable,
  output logic             chg_pulse,
  output logic [WIDTH-1:0] chg_mask,
  output logic [7:0]       chg_count,
  output logic             any_on
);

  // Counter value on the cycle that completes a full disagreeing run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] differ_c;
  logic [WIDTH-1:0] accept_c;
  logic [WIDTH-1:0] stable_next_c;

  // Two-flop synchronizer; nothing downstream looks at sw_in directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // A bit accepts on the edge where its run of disagreement reaches
  // STABLE_CYCLES; the new debounced vector is formed here so that
  // any_on can be registered from it on the same edge.
  always_comb begin
    differ_c      = sync2 ^ sw_stable;
    accept_c      = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      accept_c[i] = differ_c[i] && (cnt[i] == CNT_LAST);
    end
    stable_next_c = sw_stable ^ accept_c;
  end

  // Per-bit stability counters; agreement or acceptance restarts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (!differ_c[i] || accept_c[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced outputs and change reporting, all updated on the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_stable <= '0;
      chg_pulse <= 1'b0;
      chg_mask  <= '0;
      chg_count <= 8'd0;
      any_on    <= 1'b0;
    end else begin
      sw_stable <= stable_next_c;
      chg_pulse <= |accept_c;
      chg_mask  <= accept_c;
      any_on    <= |stable_next_c;
      // One event per edge regardless of how many bits accepted; wraps.
      if (|accept_c) begin
        chg_count <= chg_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
// Self-checking bench for sw_debounce with WIDTH=8, STABLE_CYCLES=4.
// The reference model keeps a short history of the raw input as sampled on
// each clock edge. A bit of the debounced value flips on the edge where the
// synchronized input (two edges late) has disagreed with it on each of the
// last STABLE_CYCLES edges.
// -----------------------------------------------------------------------------
module tb_sw_debounce;

  localparam int unsigned W = 8;
  localparam int unsigned S = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_in;
  logic [W-1:0] sw_stable;
  logic         chg_pulse;
  logic [W-1:0] chg_mask;
  logic [7:0]   chg_count;
  logic         any_on;

  int total;
  int bad;

  sw_debounce #(
    .WIDTH        (W),
    .STABLE_CYCLES(S),
    .CNT_W        (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_in     (sw_in),
    .sw_stable (sw_stable),
    .chg_pulse (chg_pulse),
    .chg_mask  (chg_mask),
    .chg_count (chg_count),
    .any_on    (any_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[0] is the input sampled on the previous edge; the synchronized
  // level seen on the current edge is hist[1], so hist[1..S] is the window.
  logic [W-1:0] hist [0:S];
  logic [W-1:0] m_stable;
  logic         m_pulse;
  logic [W-1:0] m_mask;
  logic [7:0]   m_count;
  logic         m_any;
  logic [W-1:0] m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= int'(S); k++) hist[k] <= '0;
      m_stable <= '0;
      m_pulse  <= 1'b0;
      m_mask   <= '0;
      m_count  <= 8'd0;
      m_any    <= 1'b0;
    end else begin
      m_acc = '1;
      for (int k = 1; k <= int'(S); k++) m_acc = m_acc & (hist[k] ^ m_stable);
      for (int k = int'(S); k >= 1; k--) hist[k] <= hist[k-1];
      hist[0]  <= sw_in;
      m_stable <= m_stable ^ m_acc;
      m_pulse  <= (m_acc != '0);
      m_mask   <= m_acc;
      m_count  <= m_count + ((m_acc != '0) ? 8'd1 : 8'd0);
      m_any    <= ((m_stable ^ m_acc) != '0);
    end
  end

  // ---------------- scenarios ----------------
  // All tasks start and end just after a falling edge; inputs change there.

  task automatic test_reset;
    rst   = 1'b0;
    sw_in = 8'hFF;
    @(negedge clk);
    total++;
    if ({sw_stable, chg_pulse, chg_mask, chg_count, any_on} !== 26'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0",
               {sw_stable, chg_pulse, chg_mask, chg_count, any_on});
    end
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if ({sw_stable, chg_pulse, chg_mask, chg_count, any_on} !==
          {m_stable, m_pulse, m_mask, m_count, m_any}) begin
        bad++;
        $display("FAIL reset_model k=%0d: got %h want %h", k,
                 {sw_stable, chg_pulse, chg_mask, chg_count, any_on},
                 {m_stable, m_pulse, m_mask, m_count, m_any});
      end
      total++;
      if (k < 5) begin
        if (sw_stable !== 8'h00 || chg_pulse !== 1'b0) begin
          bad++;
          $display("FAIL reset_early k=%0d: stable=%h pulse=%b want 00/0",
                   k, sw_stable, chg_pulse);
        end
      end else if (k == 5) begin
        if ({sw_stable, chg_pulse, chg_mask, chg_count, any_on} !==
            {8'hFF, 1'b1, 8'hFF, 8'd1, 1'b1}) begin
          bad++;
          $display("FAIL reset_accept: got %h want %h",
                   {sw_stable, chg_pulse, chg_mask, chg_count, any_on},
                   {8'hFF, 1'b1, 8'hFF, 8'd1, 1'b1});
        end
      end else begin
        if (chg_pulse !== 1'b0 || chg_count !== 8'd1 || sw_stable !== 8'hFF) begin
          bad++;
          $display("FAIL reset_after k=%0d: pulse=%b count=%0d stable=%h",
                   k, chg_pulse, chg_count, sw_stable);
        end
      end
    end
  endtask

  task automatic test_glitch;
    rst   = 1'b0;
    sw_in = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 12; j++) begin
      sw_in = (j < 3) ? 8'h08 : 8'h00;
      @(negedge clk);
      total++;
      if ({sw_stable, chg_pulse, chg_mask, chg_count, any_on} !==
          {m_stable, m_pulse, m_mask, m_count, m_any}) begin
        bad++;
        $display("FAIL glitch_model j=%0d: got %h want %h", j,
                 {sw_stable, chg_pulse, chg_mask, chg_count, any_on},
                 {m_stable, m_pulse, m_mask, m_count, m_any});
      end
      total++;
      if (sw_stable !== 8'h00 || chg_pulse !== 1'b0 || chg_count !== 8'd0) begin
        bad++;
        $display("FAIL glitch j=%0d: stable=%h pulse=%b count=%0d want 00/0/0",
                 j, sw_stable, chg_pulse, chg_count);
      end
    end
  endtask

  task automatic test_bounce;
    int pulses;
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      sw_in = (j == 1) ? 8'h00 : 8'h20;
      @(negedge clk);
      if (chg_pulse === 1'b1) pulses++;
      total++;
      if ({sw_stable, chg_pulse, chg_mask, chg_count, any_on} !==
          {m_stable, m_pulse, m_mask, m_count, m_any}) begin
        bad++;
        $display("FAIL bounce_model j=%0d: got %h want %h", j,
                 {sw_stable, chg_pulse, chg_mask, chg_count, any_on},
                 {m_stable, m_pulse, m_mask, m_count, m_any});
      end
      total++;
      if (j == 7) begin
        if (chg_pulse !== 1'b1 || chg_mask !== 8'h20 || sw_stable !== 8'h20) begin
          bad++;
          $display("FAIL bounce_accept: pulse=%b mask=%h stable=%h want 1/20/20",
                   chg_pulse, chg_mask, sw_stable);
        end
      end else if (chg_pulse !== 1'b0) begin
        bad++;
        $display("FAIL bounce_extra j=%0d: pulse=%b want 0", j, chg_pulse);
      end
    end
    total++;
    if (pulses != 1 || chg_count !== 8'd1) begin
      bad++;
      $display("FAIL bounce_count: pulses=%0d count=%0d want 1/1", pulses, chg_count);
    end
  endtask

  task automatic test_two_bits;
    for (int j = 0; j < 10; j++) begin
      sw_in = (j == 0) ? 8'h21 : 8'hA1;
      @(negedge clk);
      total++;
      if ({sw_stable, chg_pulse, chg_mask, chg_count, any_on} !==
          {m_stable, m_pulse, m_mask, m_count, m_any}) begin
        bad++;
        $display("FAIL two_model j=%0d: got %h want %h", j,
                 {sw_stable, chg_pulse, chg_mask, chg_count, any_on},
                 {m_stable, m_pulse, m_mask, m_count, m_any});
      end
      total++;
      if (j == 5) begin
        if (chg_pulse !== 1'b1 || chg_mask !== 8'h01 || chg_count !== 8'd2) begin
          bad++;
          $display("FAIL two_first: pulse=%b mask=%h count=%0d want 1/01/2",
                   chg_pulse, chg_mask, chg_count);
        end
      end else if (j == 6) begin
        if (chg_pulse !== 1'b1 || chg_mask !== 8'h80 || chg_count !== 8'd3) begin
          bad++;
          $display("FAIL two_second: pulse=%b mask=%h count=%0d want 1/80/3",
                   chg_pulse, chg_mask, chg_count);
        end
      end else if (chg_pulse !== 1'b0 || chg_mask !== 8'h00) begin
        bad++;
        $display("FAIL two_idle j=%0d: pulse=%b mask=%h want 0/00",
                 j, chg_pulse, chg_mask);
      end
    end
  endtask

  task automatic test_wrap;
    int pulses;
    pulses = 0;
    for (int t = 0; t < 256; t++) begin
      sw_in = sw_in ^ 8'h02;
      for (int j = 0; j < 7; j++) begin
        @(negedge clk);
        if (chg_pulse === 1'b1) pulses++;
        total++;
        if ({sw_stable, chg_pulse, chg_mask, chg_count, any_on} !==
            {m_stable, m_pulse, m_mask, m_count, m_any}) begin
          bad++;
          $display("FAIL wrap_model t=%0d j=%0d: got %h want %h", t, j,
                   {sw_stable, chg_pulse, chg_mask, chg_count, any_on},
                   {m_stable, m_pulse, m_mask, m_count, m_any});
        end
      end
    end
    total++;
    if (pulses != 256 || chg_count !== 8'd3 || sw_stable !== 8'hA1) begin
      bad++;
      $display("FAIL wrap: pulses=%0d count=%0d stable=%h want 256/3/a1",
               pulses, chg_count, sw_stable);
    end
  endtask

  task automatic test_random;
    int hold;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        sw_in = sw_in ^ 8'($urandom_range(0, 255));
        hold  = (($urandom & 3) == 0) ? int'($urandom_range(5, 12))
                                      : int'($urandom_range(1, 4));
      end
      hold--;
      @(negedge clk);
      total++;
      if ({sw_stable, chg_pulse, chg_mask, chg_count, any_on} !==
          {m_stable, m_pulse, m_mask, m_count, m_any}) begin
        bad++;
        $display("FAIL random_model c=%0d: got %h want %h", c,
                 {sw_stable, chg_pulse, chg_mask, chg_count, any_on},
                 {m_stable, m_pulse, m_mask, m_count, m_any});
      end
    end
  endtask

  task automatic test_reset_mid;
    rst   = 1'b0;
    sw_in = 8'h00;
    @(negedge clk);
    rst   = 1'b1;
    sw_in = 8'h40;
    repeat (8) @(negedge clk);
    total++;
    if (sw_stable !== 8'h40 || chg_count !== 8'd1) begin
      bad++;
      $display("FAIL mid_setup: stable=%h count=%0d want 40/1", sw_stable, chg_count);
    end
    // Bit 2 rises; after the fourth edge its counter sits at 2.
    sw_in = 8'h44;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({sw_stable, chg_pulse, chg_mask, chg_count, any_on} !== 26'd0) begin
      bad++;
      $display("FAIL mid_async: got %h want 0",
               {sw_stable, chg_pulse, chg_mask, chg_count, any_on});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if ({sw_stable, chg_pulse, chg_mask, chg_count, any_on} !==
          {m_stable, m_pulse, m_mask, m_count, m_any}) begin
        bad++;
        $display("FAIL mid_model k=%0d: got %h want %h", k,
                 {sw_stable, chg_pulse, chg_mask, chg_count, any_on},
                 {m_stable, m_pulse, m_mask, m_count, m_any});
      end
      total++;
      if (k < 5) begin
        if (sw_stable !== 8'h00 || chg_pulse !== 1'b0) begin
          bad++;
          $display("FAIL mid_early k=%0d: stable=%h pulse=%b want 00/0",
                   k, sw_stable, chg_pulse);
        end
      end else if (k == 5) begin
        if ({sw_stable, chg_pulse, chg_mask, chg_count, any_on} !==
            {8'h44, 1'b1, 8'h44, 8'd1, 1'b1}) begin
          bad++;
          $display("FAIL mid_accept: got %h want %h",
                   {sw_stable, chg_pulse, chg_mask, chg_count, any_on},
                   {8'h44, 1'b1, 8'h44, 8'd1, 1'b1});
        end
      end else if (chg_pulse !== 1'b0 || chg_count !== 8'd1) begin
        bad++;
        $display("FAIL mid_after k=%0d: pulse=%b count=%0d want 0/1",
                 k, chg_pulse, chg_count);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    sw_in = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_glitch();
    test_bounce();
    test_two_bits();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
